// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Single-word SPI master (8/16 bit, all four modes, MSB/LSB
//               first) with programmable SCK half-period of clk_div+1 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      data_tx,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             msb_first,
    input  logic             two_bytes,
    input  logic [DIV_W-1:0] clk_div,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             cs,
    output logic [15:0]      data_rx,
    output logic             busy,
    output logic             end_of_byte
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_XFER  = 2'd2,
        S_TRAIL = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_cpha;
    logic             r_msb;
    logic             r_two;
    logic [5:0]       r_edge;
    logic [15:0]      r_tx;
    logic [15:0]      r_rx;
    logic             r_sck;
    logic             r_mosi;
    logic             r_cs;
    logic             r_busy;
    logic             r_eob;
    logic [15:0]      r_data_rx;

    logic             w_accept;
    logic             w_edge;
    logic             w_done;
    logic             w_cnt_zero;
    logic [5:0]       w_n2;
    logic [5:0]       w_edge_num;
    logic             w_leading;
    logic             w_last;
    logic             w_sample;
    logic             w_advance;
    logic [15:0]      w_tx_load;
    logic             w_load_bit;
    logic             w_tx_bit;
    logic [15:0]      w_rx_next;
    logic [15:0]      w_rx_final;

    function automatic logic [15:0] f_shift(input logic [15:0] v, input logic msb);
        return msb ? {v[14:0], 1'b0} : {1'b0, v[15:1]};
    endfunction

    assign w_cnt_zero = (r_cnt == '0);
    assign w_n2       = r_two ? 6'd32 : 6'd16;
    assign w_edge_num = r_edge + 6'd1;
    assign w_leading  = w_edge_num[0];
    assign w_last     = (w_edge_num == w_n2);

    // cpha=0: sample on leading, shift on trailing (never after the final edge).
    // cpha=1: shift on leading, sample on trailing.
    assign w_sample  = w_edge && (r_cpha ? !w_leading : w_leading);
    assign w_advance = w_edge && (r_cpha ? w_leading : (!w_leading && !w_last));

    // 8-bit MSB-first words are left-aligned so bit 15 is always the MSB head.
    assign w_tx_load  = msb_first ? (two_bytes ? data_tx : {data_tx[7:0], 8'h00}) : data_tx;
    assign w_load_bit = msb_first ? w_tx_load[15] : w_tx_load[0];
    assign w_tx_bit   = r_msb ? r_tx[15] : r_tx[0];
    assign w_rx_next  = r_msb ? {r_rx[14:0], miso} : {miso, r_rx[15:1]};
    assign w_rx_final = (r_msb || r_two) ? r_rx : {8'h00, r_rx[15:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_edge      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !r_eob) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LEAD;
                end
            end
            S_LEAD: begin
                if (w_cnt_zero) begin
                    w_edge      = 1'b1;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (w_cnt_zero) begin
                    if (r_edge == w_n2) begin
                        w_state_nxt = S_TRAIL;
                    end else begin
                        w_edge = 1'b1;
                    end
                end
            end
            S_TRAIL: begin
                if (w_cnt_zero) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= '0;
            r_cpha    <= 1'b0;
            r_msb     <= 1'b0;
            r_two     <= 1'b0;
            r_edge    <= 6'd0;
            r_tx      <= 16'h0000;
            r_rx      <= 16'h0000;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs      <= 1'b1;
            r_busy    <= 1'b0;
            r_eob     <= 1'b0;
            r_data_rx <= 16'h0000;
        end else begin
            r_eob <= w_done;
            if (w_accept) begin
                r_div  <= clk_div;
                r_cpha <= cpha;
                r_msb  <= msb_first;
                r_two  <= two_bytes;
                r_cnt  <= clk_div;
                r_edge <= 6'd0;
                r_sck  <= cpol;
                r_cs   <= 1'b0;
                r_busy <= 1'b1;
                r_rx   <= 16'h0000;
                if (!cpha) begin
                    r_mosi <= w_load_bit;
                    r_tx   <= f_shift(w_tx_load, msb_first);
                end else begin
                    r_mosi <= 1'b0;
                    r_tx   <= w_tx_load;
                end
            end else if (r_state != S_IDLE) begin
                r_cnt <= w_cnt_zero ? r_div : r_cnt - DIV_W'(1);
                if (w_edge) begin
                    r_sck  <= ~r_sck;
                    r_edge <= w_edge_num;
                end
                if (w_sample) begin
                    r_rx <= w_rx_next;
                end
                if (w_advance) begin
                    r_mosi <= w_tx_bit;
                    r_tx   <= f_shift(r_tx, r_msb);
                end
                if (w_done) begin
                    r_cs      <= 1'b1;
                    r_busy    <= 1'b0;
                    r_mosi    <= 1'b0;
                    r_data_rx <= w_rx_final;
                end
            end
        end
    end

    // SCK follows cpol combinationally while idle so mode changes show at once.
    assign sck         = (r_state == S_IDLE) ? cpol : r_sck;
    assign mosi        = r_mosi;
    assign cs          = r_cs;
    assign busy        = r_busy;
    assign end_of_byte = r_eob;
    assign data_rx     = r_data_rx;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Directed self-checking bench for spi_master with an SPI slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data_tx = 16'h0000;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic        msb_first = 1'b1;
    logic        two_bytes = 1'b0;
    logic [7:0]  clk_div = 8'd0;
    logic        sck, mosi, cs, busy, end_of_byte;
    logic [15:0] data_rx;
    wire         miso;

    logic        loopback = 1'b1;
    logic        s_miso = 1'b0;
    assign miso = loopback ? mosi : s_miso;

    spi_master #(.DIV_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .data_tx(data_tx), .cpol(cpol),
        .cpha(cpha), .msb_first(msb_first), .two_bytes(two_bytes), .clk_div(clk_div),
        .sck(sck), .mosi(mosi), .miso(miso), .cs(cs), .data_rx(data_rx),
        .busy(busy), .end_of_byte(end_of_byte)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // slave configuration and observations
    logic [15:0] s_tx_word = 16'h0000;
    logic        s_cpha = 1'b0;
    logic        s_msb = 1'b1;
    int          s_n = 8;
    int          cyc = 0, busy_total = 0, eob_total = 0;
    int          s_edges = 0, s_rxcnt = 0, s_txcnt = 0;
    int          h_min = 0, h_max = 0, t_last = 0;
    logic [15:0] s_rx = 16'h0000;
    logic        prev_sck = 1'b0, prev_cs = 1'b1;

    function automatic logic sbit(input logic [15:0] w, input int idx, input logic msb, input int n);
        if (idx >= n) return 1'b0;
        return msb ? w[n-1-idx] : w[idx];
    endfunction

    always @(negedge clk) begin
        int h;
        cyc++;
        if (busy === 1'b1) busy_total++;
        if (end_of_byte === 1'b1) eob_total++;
        if (cs === 1'b0) begin
            if (prev_cs === 1'b1) begin
                s_edges = 0; s_rxcnt = 0; s_txcnt = 0; s_rx = 16'h0000;
                h_min = 1000; h_max = 0; t_last = cyc;
                if (!s_cpha) begin
                    s_miso = sbit(s_tx_word, 0, s_msb, s_n);
                    s_txcnt = 1;
                end
            end else if (sck !== prev_sck) begin
                s_edges++;
                if (s_edges > 1) begin
                    h = cyc - t_last;
                    if (h < h_min) h_min = h;
                    if (h > h_max) h_max = h;
                end
                t_last = cyc;
                if (((s_edges % 2) == 1) != s_cpha) begin
                    if (s_rxcnt < s_n) begin
                        if (s_msb) s_rx[s_n-1-s_rxcnt] = mosi;
                        else       s_rx[s_rxcnt] = mosi;
                        s_rxcnt++;
                    end
                end else if (s_txcnt < s_n) begin
                    s_miso = sbit(s_tx_word, s_txcnt, s_msb, s_n);
                    s_txcnt++;
                end
            end
        end
        prev_sck = sck;
        prev_cs  = cs;
    end

    task automatic setup(input logic [15:0] d, input logic pol, input logic pha, input logic msb,
                         input logic two, input logic [7:0] div, input logic lb, input logic [15:0] sw);
        data_tx = d; cpol = pol; cpha = pha; msb_first = msb; two_bytes = two; clk_div = div;
        loopback = lb; s_tx_word = sw; s_cpha = pha; s_msb = msb; s_n = two ? 16 : 8;
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_eob(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (end_of_byte === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s_eob_timeout: got no end_of_byte, want one within 3000 cycles", tag); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (cs !== 1'b1)   begin n_bad++; $display("FAIL rst_cs: got %b want 1", cs); end
        n_cmp++; if (sck !== 1'b0)  begin n_bad++; $display("FAIL rst_sck: got %b want 0", sck); end
        n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL rst_mosi: got %b want 0", mosi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (end_of_byte !== 1'b0) begin n_bad++; $display("FAIL rst_eob: got %b want 0", end_of_byte); end
        n_cmp++; if (data_rx !== 16'h0000) begin n_bad++; $display("FAIL rst_data_rx: got %h want 0000", data_rx); end
        cpol = 1'b1; #1;
        n_cmp++; if (sck !== 1'b1)  begin n_bad++; $display("FAIL rst_sck_live_cpol: got %b want 1", sck); end
        cpol = 1'b0;
        // reset wins over a simultaneous start
        pulse_start;
        @(negedge clk);
        n_cmp++; if (cs !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_priority: got cs=%b busy=%b want cs=1 busy=0", cs, busy); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_mode0;
        int b0, e0;
        setup(16'h00A5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 16'h0000);
        b0 = busy_total; e0 = eob_total;
        pulse_start;
        wait_eob("m0");
        repeat (2) @(negedge clk);
        n_cmp++; if (data_rx !== 16'h00A5) begin n_bad++; $display("FAIL m0_data_rx: got %h want 00a5", data_rx); end
        n_cmp++; if (s_rx !== 16'h00A5)    begin n_bad++; $display("FAIL m0_slave_rx: got %h want 00a5", s_rx); end
        n_cmp++; if (s_edges !== 16)       begin n_bad++; $display("FAIL m0_edges: got %0d want 16", s_edges); end
        n_cmp++; if (h_min !== 4 || h_max !== 4) begin n_bad++; $display("FAIL m0_half_period: got %0d..%0d want 4..4", h_min, h_max); end
        n_cmp++; if (busy_total - b0 !== 72) begin n_bad++; $display("FAIL m0_busy_cycles: got %0d want 72", busy_total - b0); end
        n_cmp++; if (eob_total - e0 !== 1) begin n_bad++; $display("FAIL m0_eob_pulses: got %0d want 1", eob_total - e0); end
        n_cmp++; if (cs !== 1'b1 || mosi !== 1'b0) begin n_bad++; $display("FAIL m0_idle_after: got cs=%b mosi=%b want cs=1 mosi=0", cs, mosi); end
    endtask

    task automatic test_mode3;
        setup(16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 16'hBEEF);
        #1;
        n_cmp++; if (sck !== 1'b1) begin n_bad++; $display("FAIL m3_sck_idle_before: got %b want 1", sck); end
        pulse_start;
        wait_eob("m3");
        repeat (2) @(negedge clk);
        n_cmp++; if (data_rx !== 16'hBEEF) begin n_bad++; $display("FAIL m3_data_rx: got %h want beef", data_rx); end
        n_cmp++; if (s_rx !== 16'h1234)    begin n_bad++; $display("FAIL m3_slave_rx: got %h want 1234", s_rx); end
        n_cmp++; if (s_edges !== 32)       begin n_bad++; $display("FAIL m3_edges: got %0d want 32", s_edges); end
        n_cmp++; if (sck !== 1'b1)         begin n_bad++; $display("FAIL m3_sck_idle_after: got %b want 1", sck); end
    endtask

    task automatic test_modes12;
        int b0;
        for (int m = 1; m <= 2; m++) begin
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            setup(16'h0081, (m == 2), (m == 1), 1'b1, 1'b0, 8'd0, 1'b0, 16'h003C);
            b0 = busy_total;
            pulse_start;
            wait_eob("m12");
            repeat (2) @(negedge clk);
            n_cmp++; if (data_rx !== 16'h003C) begin n_bad++; $display("FAIL mode%0d_data_rx: got %h want 003c", m, data_rx); end
            n_cmp++; if (s_rx !== 16'h0081)    begin n_bad++; $display("FAIL mode%0d_slave_rx: got %h want 0081", m, s_rx); end
            n_cmp++; if (h_min !== 1 || h_max !== 1) begin n_bad++; $display("FAIL mode%0d_half_period: got %0d..%0d want 1..1", m, h_min, h_max); end
            n_cmp++; if (busy_total - b0 !== 18) begin n_bad++; $display("FAIL mode%0d_busy_cycles: got %0d want 18", m, busy_total - b0); end
        end
    endtask

    task automatic test_back_to_back;
        int e0;
        setup(16'h0055, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 16'h0000);
        e0 = eob_total;
        pulse_start;
        repeat (10) @(posedge clk);
        data_tx = 16'h00FF;
        pulse_start;
        wait_eob("b2b_first");
        n_cmp++; if (cs !== 1'b1)          begin n_bad++; $display("FAIL b2b_cs_high_gap: got %b want 1", cs); end
        n_cmp++; if (data_rx !== 16'h0055) begin n_bad++; $display("FAIL b2b_first_data_rx: got %h want 0055", data_rx); end
        n_cmp++; if (s_edges !== 16)       begin n_bad++; $display("FAIL b2b_first_edges: got %0d want 16", s_edges); end
        @(posedge clk); #1 data_tx = 16'h003A; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_cmp++; if (cs !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_start: got cs=%b busy=%b want cs=0 busy=1", cs, busy); end
        wait_eob("b2b_second");
        n_cmp++; if (data_rx !== 16'h003A) begin n_bad++; $display("FAIL b2b_second_data_rx: got %h want 003a", data_rx); end
        // start held on the end_of_byte cycle only must be ignored
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || cs !== 1'b1) begin n_bad++; $display("FAIL b2b_start_on_eob: got busy=%b cs=%b want busy=0 cs=1", busy, cs); end
        n_cmp++; if (eob_total - e0 !== 2) begin n_bad++; $display("FAIL b2b_eob_pulses: got %0d want 2", eob_total - e0); end
    endtask

    task automatic test_reset_mid;
        int e0;
        bit ok = 1'b0;
        setup(16'hF0F0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 16'h0000);
        pulse_start;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cs === 1'b0 && s_edges == 5) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_edge5_timeout: got no edge 5, want edge 5 within 500 cycles"); end
        e0 = eob_total;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cs !== 1'b1)   begin n_bad++; $display("FAIL rmid_cs: got %b want 1", cs); end
        n_cmp++; if (sck !== 1'b0)  begin n_bad++; $display("FAIL rmid_sck: got %b want 0", sck); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (data_rx !== 16'h0000) begin n_bad++; $display("FAIL rmid_data_rx: got %h want 0000", data_rx); end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++; if (eob_total - e0 !== 0) begin n_bad++; $display("FAIL rmid_no_eob: got %0d pulses want 0", eob_total - e0); end
    endtask

    task automatic test_cfg_change;
        int b0;
        setup(16'h0069, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 16'h0000);
        b0 = busy_total;
        pulse_start;
        repeat (6) @(posedge clk);
        #1 clk_div = 8'd5; two_bytes = 1'b1; cpha = 1'b1; msb_first = 1'b0;
        wait_eob("cfg");
        repeat (2) @(negedge clk);
        n_cmp++; if (s_edges !== 16)       begin n_bad++; $display("FAIL cfg_edges: got %0d want 16", s_edges); end
        n_cmp++; if (h_min !== 2 || h_max !== 2) begin n_bad++; $display("FAIL cfg_half_period: got %0d..%0d want 2..2", h_min, h_max); end
        n_cmp++; if (busy_total - b0 !== 36) begin n_bad++; $display("FAIL cfg_busy_cycles: got %0d want 36", busy_total - b0); end
        n_cmp++; if (data_rx !== 16'h0069) begin n_bad++; $display("FAIL cfg_data_rx: got %h want 0069", data_rx); end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode3;
        test_modes12;
        test_back_to_back;
        test_reset_mid;
        test_cfg_change;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, want finish before 2 ms");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
